// File: rtl/sobel_mdc_out_pel_packer.sv
// Packs consecutive PEL_WIDTH pixels from the Sobel MDC out_pel stream into
// OUT_WIDTH words with byte strobes; flushes a partial tail and pulses done.
module sobel_mdc_out_pel_packer #(
  parameter int unsigned PEL_WIDTH = 8,
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IN_WIDTH-1:0]    in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_WIDTH-1:0]   out_data_o,
  output logic [OUT_WIDTH/8-1:0] out_strb_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   cnt_words_o
);

  localparam int unsigned LANES     = OUT_WIDTH / PEL_WIDTH;
  localparam int unsigned STRB_W    = OUT_WIDTH / 8;
  localparam int unsigned PEL_BYTES = PEL_WIDTH / 8;
  localparam int unsigned IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [OUT_WIDTH-1:0] acc_q;
  logic [STRB_W-1:0]    acc_strb_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic [STRB_W-1:0]    out_strb_q;
  logic                 done_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 in_ready_c;
  logic                 accept;
  logic                 out_fire;
  logic                 start_ok;
  logic                 word_done;
  logic                 done_set;
  logic                 busy_d;
  logic [PEL_WIDTH-1:0] pel;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [STRB_W-1:0]    strb_nxt;

  // Bits above the pixel carry nothing for this block.
  generate
    if (IN_WIDTH > PEL_WIDTH) begin : g_in_hi
      logic unused_in_hi;
      assign unused_in_hi = ^in_data_i[IN_WIDTH-1:PEL_WIDTH];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i && (len_i != '0)) state_d = RUN;
      RUN:     if (accept && (rem_q == CNT_WIDTH'(1))) state_d = DRAIN;
      DRAIN:   if (out_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Output / handshake decode.
  always_comb begin
    in_ready_c = 1'b0;
    done_set   = 1'b0;
    start_ok   = 1'b0;
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    unique case (state_q)
      IDLE: begin
        start_ok = start_i;
        done_set = start_i && (len_i == '0);
      end
      RUN:     in_ready_c = ~out_valid_q | out_ready_i;
      DRAIN:   done_set = out_fire;
      default: ;
    endcase
  end

  // Lane insertion of the incoming pixel.
  always_comb begin
    pel       = in_data_i[PEL_WIDTH-1:0];
    accept    = in_valid_i & in_ready_c;
    out_fire  = out_valid_q & out_ready_i;
    word_done = accept & ((rem_q == CNT_WIDTH'(1)) || (idx_q == IDX_W'(LANES - 1)));
    acc_nxt   = acc_q;
    strb_nxt  = acc_strb_q;
    for (int l = 0; l < LANES; l++) begin
      if (idx_q == IDX_W'(l)) begin
        acc_nxt[l*PEL_WIDTH +: PEL_WIDTH]  = pel;
        strb_nxt[l*PEL_BYTES +: PEL_BYTES] = '1;
      end
    end
  end

  // Accumulator, output register and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      acc_strb_q  <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else if (clear_i) begin
      acc_q       <= '0;
      acc_strb_q  <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (start_ok) begin
        rem_q      <= len_i;
        cnt_q      <= '0;
        idx_q      <= '0;
        acc_q      <= '0;
        acc_strb_q <= '0;
      end
      if (accept) begin
        rem_q <= rem_q - CNT_WIDTH'(1);
        if (word_done) begin
          acc_q      <= '0;
          acc_strb_q <= '0;
          idx_q      <= '0;
        end else begin
          acc_q      <= acc_nxt;
          acc_strb_q <= strb_nxt;
          idx_q      <= idx_q + IDX_W'(1);
        end
      end
      // A completed word may replace one leaving on the same edge.
      if (word_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_nxt;
        out_strb_q  <= strb_nxt;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      if (out_fire) cnt_q <= cnt_q + CNT_WIDTH'(1);
      done_q <= done_set;
      busy_q <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_c;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign cnt_words_o = cnt_q;

endmodule

// File: tb/tb_sobel_mdc_out_pel_packer.sv
// Directed bench for sobel_mdc_out_pel_packer: expected words are queued when
// a job is set up and popped as output handshakes are observed.
module tb_sobel_mdc_out_pel_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        done;
  logic        busy;
  logic [31:0] cnt_words;

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;
  int d0;
  logic [35:0] exp_q[$];
  logic [7:0]  px_q[$];
  logic [35:0] sb_e;
  logic [31:0] held;

  always #5 clk = ~clk;

  sobel_mdc_out_pel_packer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .start_i     (start),
    .len_i       (len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_strb_o  (out_strb),
    .done_o      (done),
    .busy_o      (busy),
    .cnt_words_o (cnt_words)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_extra observed=%0h expected=none", {out_strb, out_data});
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_word", 64'({out_strb, out_data}), 64'(sb_e));
      end
    end
    if (rst_n && done) done_pulses++;
  end

  task automatic build_expected();
    logic [35:0] w;
    for (int i = 0; i < px_q.size(); i += 4) begin
      w = '0;
      for (int l = 0; l < 4; l++) begin
        if (i + l < px_q.size()) begin
          w[l*8 +: 8] = px_q[i+l];
          w[32 + l]   = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < px_q.size(); i++) send({24'($urandom()), px_q[i]});
  endtask

  task automatic start_job(input logic [31:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("cnt_zero_after_start", 64'(cnt_words), 64'(0));
  endtask

  task automatic wait_done(input logic [31:0] exp_cnt);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("cnt_words", 64'(cnt_words), 64'(exp_cnt));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
    check("sb_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 64'({in_ready, out_valid, done, busy}), 64'(0));
    check({tag, "_data"}, 64'({out_strb, out_data}), 64'(0));
    check({tag, "_cnt"}, 64'(cnt_words), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full packing, back-to-back.
    d0 = done_pulses;
    px_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    build_expected();
    start_job(8);
    check("busy_in_run", 64'(busy), 64'(1));
    send_all();
    wait_done(2);
    check("done_pulses_full", 64'(done_pulses - d0), 64'(1));

    // Tail flush.
    px_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    build_expected();
    start_job(5);
    send_all();
    wait_done(2);

    // Backpressure on the first word.
    px_q.delete();
    for (int i = 0; i < 12; i++) px_q.push_back(8'($urandom()));
    build_expected();
    start_job(12);
    fork
      send_all();
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        held = out_data;
        repeat (10) begin
          @(posedge clk);
          #1;
          check("bp_data_stable", 64'(out_data), 64'(held));
          check("bp_in_ready_low", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
      end
    join
    wait_done(3);

    // Zero length start.
    d0 = done_pulses;
    start_job(0);
    check("zero_len_done", 64'(done), 64'(1));
    check("zero_len_no_beat", 64'({out_valid, busy}), 64'(0));
    @(posedge clk);
    #1;
    check("zero_len_done_once", 64'(done), 64'(0));

    // start_i during RUN is ignored.
    px_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_expected();
    start_job(4);
    send({24'h0, px_q[0]});
    send({24'h0, px_q[1]});
    start = 1'b1;
    len   = 32'd99;
    @(posedge clk);
    #1;
    start = 1'b0;
    send({24'h0, px_q[2]});
    send({24'h0, px_q[3]});
    wait_done(1);

    // Clear mid-job.
    d0 = done_pulses;
    px_q = '{8'h5A, 8'h6B, 8'h7C};
    start_job(8);
    send_all();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_all_zero("clear");
    repeat (3) @(posedge clk);
    #1;
    check("clear_no_done", 64'(done_pulses - d0), 64'(0));
    px_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    build_expected();
    start_job(4);
    send_all();
    wait_done(1);

    // Upper bits ignored, then async reset while in DRAIN.
    out_ready = 1'b0;
    start_job(1);
    send(32'hFFFF_FF3C);
    check("hi_bits_word", 64'({out_strb, out_data}), 64'({4'h1, 32'h0000_003C}));
    check("drain_busy", 64'({busy, out_valid}), 64'(3));
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_sb", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
